serial_maxmin_unit: RTL
=======================

Name: serial_maxmin_unit

Overview:
- Sequential, digit-serial unsigned comparator for two WIDTH-bit operands.
- Scans MSB-first and returns max, min and the a>b flag through valid/ready handshakes.
- Area-reduced counterpart of the flat 32-bit unsigned max network in the FHE benchmark set. It fits datapaths where one comparison per several cycles is acceptable and gate depth must stay bounded per cycle.

Parameters:
- WIDTH, 32: operand width in bits.
- DW, 1: digit width compared per SCAN cycle. WIDTH % DW must be 0. N = WIDTH/DW.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  unit can accept an operand pair.
- in_a  in  WIDTH  operand a (unsigned).
- in_b  in  WIDTH  operand b (unsigned).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_max  out  WIDTH  max(a,b).
- out_min  out  WIDTH  min(a,b).
- out_a_gt_b  out  1  1 iff a > b strictly.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - in_ready=1 from the following cycle. out_valid=0, out_max=0, out_min=0, out_a_gt_b=0.
  - Operand registers, digit index and decision flags are cleared.
  - rst has priority over every other event, including reset mid-SCAN or mid-DONE; the pending result is discarded.
- FSM has three states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - on in_valid&&in_ready: latch in_a/in_b, idx=N-1, decided=0, gt=0, then go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle compares a digit [idx*DW +: DW] of a and b.
  - If decided==0 and the digits differ: set decided=1 and gt=(a_digit > b_digit).
  - Decrements idx.
  - When idx==0 was processed this cycle, go to DONE.
- DONE:
  - out_valid=1.
  - out_max = gt ? a : b. out_min = gt ? b : a. out_a_gt_b = gt.
  - All outputs are registered and held stable while out_valid && !out_ready.
  - On out_valid&&out_ready go to IDLE; in_ready=1 the next cycle. Results are not overlapped with new acceptances.
- Latency (feature off): acceptance edge = cycle 0; SCAN occupies cycles 1..N; out_valid rises at cycle N+1 (33 for defaults). Throughput is at most one pair per N+2 cycles with out_ready held high.
- Equal operands: gt=0, out_a_gt_b=0, out_max=out_min=a.
- Input changes on in_a/in_b after acceptance have no effect.
- out_ready asserted while out_valid=0 is ignored.
- in_valid asserted outside IDLE is ignored; no operand is lost because in_ready=0.
- Arithmetic is purely unsigned; no sign handling. Outputs carry no X under any state after reset.

Optional Feature:
- Macro: SERIAL_MAXMIN_EARLY_EXIT_EN.
- Defined:
  - SCAN goes to DONE on the edge following the first differing digit, without waiting for idx==0.
  - Latency = k+1 cycles, where k is the 1-based SCAN cycle of the first differing digit counted from the MSB.
  - Equal operands still take the full N+1 cycles.
  - Adds output early_done (1 bit). It is registered, and is 1 in DONE when exit preceded idx==0, else 0. It resets to 0.
- Undefined: fixed latency N+1 cycles for all inputs. The early_done port is absent.
- Results (out_max/out_min/out_a_gt_b) are identical in both builds.

Test Plan:
- Basic, defaults, out_ready=1: a=0x0000_0005, b=0x0000_0003 -> out_valid at cycle 33; out_max=5, out_min=3, out_a_gt_b=1. in_ready=0 during cycles 1..33, back to 1 at cycle 34.
- Equal operands: a=b=0xDEAD_BEEF -> out_max=out_min=0xDEAD_BEEF, out_a_gt_b=0. With SERIAL_MAXMIN_EARLY_EXIT_EN, still cycle 33 and early_done=0.
- MSB decision plus early exit (macro on, DW=1): a=0x8000_0000, b=0x7FFF_FFFF -> out_valid at cycle 2, out_max=0x8000_0000, early_done=1. Macro off -> same values at cycle 33.
- Backpressure: a=1, b=0xFFFF_FFFF, out_ready held 0 for 10 cycles after out_valid -> outputs stable (max=0xFFFF_FFFF, min=1, gt=0). in_ready stays 0; in_valid pulses are ignored. Releasing out_ready pops the result, and in_ready=1 the next cycle.
- Reset mid-operation: accept a=7, b=9, assert rst during SCAN cycle 10 -> next cycle IDLE, in_ready=1, out_valid=0, outputs 0. A new pair a=9, b=7 then gives max=9, min=7, gt=1.
- DW=4, WIDTH=32: a=0x1234_5678, b=0x1234_5679 -> out_valid at cycle 9, out_max=0x1234_5679, out_a_gt_b=0.

Source files
------------

// File: rtl/serial_maxmin_unit_if.sv
// Handshake bundle for serial_maxmin_unit: operand request channel and result channel.
// early_done exists only when SERIAL_MAXMIN_EARLY_EXIT_EN is defined.
interface serial_maxmin_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_min;
    logic             out_a_gt_b;
`ifdef SERIAL_MAXMIN_EARLY_EXIT_EN
    logic             early_done;
`endif

    // master drives operands and consumes results; slave is the comparator
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_max, out_min, out_a_gt_b
`ifdef SERIAL_MAXMIN_EARLY_EXIT_EN
        , input early_done
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_max, out_min, out_a_gt_b
`ifdef SERIAL_MAXMIN_EARLY_EXIT_EN
        , output early_done
`endif
    );
endinterface

// File: rtl/serial_maxmin_unit.sv
// Digit-serial MSB-first unsigned max/min comparator with valid/ready handshakes.
// Optional SERIAL_MAXMIN_EARLY_EXIT_EN: leave SCAN at the first differing digit.
//
// state | meaning
// IDLE  | ready for a new operand pair
// SCAN  | comparing one DW-bit digit per cycle, MSB first
// DONE  | result held until the consumer takes it
module serial_maxmin_unit #(
    parameter int WIDTH = 32,
    parameter int DW    = 1
) (
    input  logic               clk,
    input  logic               rst,
    serial_maxmin_unit_if.slave bus
);
    localparam int N    = WIDTH / DW;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [IDXW-1:0]   idx;
    logic              decided;
    logic              gt;

    logic [DW-1:0]     a_dig;
    logic [DW-1:0]     b_dig;
    logic              dig_diff;
    logic              decided_next;
    logic              gt_next;
    logic              last_digit;
    logic              exit_now;

    // constant-index mux keeps the digit select free of variable part-selects
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDXW'(i)) begin
                a_dig = a_q[i*DW +: DW];
                b_dig = b_q[i*DW +: DW];
            end
        end
    end

    always_comb begin
        dig_diff     = (a_dig != b_dig);
        decided_next = decided | dig_diff;
        gt_next      = decided ? gt : (a_dig > b_dig);
        last_digit   = (idx == '0);
`ifdef SERIAL_MAXMIN_EARLY_EXIT_EN
        exit_now     = last_digit | (~decided & dig_diff);
`else
        exit_now     = last_digit;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            idx            <= '0;
            decided        <= 1'b0;
            gt             <= 1'b0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_max    <= '0;
            bus.out_min    <= '0;
            bus.out_a_gt_b <= 1'b0;
`ifdef SERIAL_MAXMIN_EARLY_EXIT_EN
            bus.early_done <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        a_q          <= bus.in_a;
                        b_q          <= bus.in_b;
                        idx          <= IDXW'(N - 1);
                        decided      <= 1'b0;
                        gt           <= 1'b0;
                        bus.in_ready <= 1'b0;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    decided <= decided_next;
                    gt      <= gt_next;
                    idx     <= idx - IDXW'(1);
                    if (exit_now) begin
                        bus.out_valid  <= 1'b1;
                        bus.out_max    <= gt_next ? a_q : b_q;
                        bus.out_min    <= gt_next ? b_q : a_q;
                        bus.out_a_gt_b <= gt_next;
`ifdef SERIAL_MAXMIN_EARLY_EXIT_EN
                        bus.early_done <= ~last_digit;
`endif
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
